// File: rtl/wb_write_port_ctrl.sv
// ---------------------------------------------------------------------------
// wb_write_port_ctrl
//
// Write-side controller for the ID-stage register file. The in-order
// pipeline writeback stream and the out-of-order mul/div results share the
// single register-file write port. Mul/div results wait in a small FIFO.
// Pipeline writes always win the port. A pipeline write also cancels every
// older queued mul/div result to the same register, so the write order to
// any one register always follows age order.
//
// Optional feature macro: WB_FWD_EN
//   defined   : fwd_hit/fwd_data return the youngest valid queued entry
//               whose destination is fwd_addr (x0 never hits).
//   undefined : fwd_hit = 0 and fwd_data = 0; no search logic is built.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wd   pipeline writeback (destination x0 ignored)
//   md_valid/md_ready            mul/div result handshake (ready = not full)
//   md_waddr/md_wd               mul/div result (destination x0 dropped)
//   rf_we/rf_waddr/rf_wd         registered register-file write port
//   pending                      bit r set while a valid queued entry targets xr
//   q_count                      FIFO occupancy, includes cancelled slots
//   fwd_addr/fwd_hit/fwd_data    forwarding lookup into the queue
// ---------------------------------------------------------------------------
module wb_write_port_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_waddr,
    input  logic [XLEN-1:0]        pipe_wd,
    input  logic                   md_valid,
    output logic                   md_ready,
    input  logic [4:0]             md_waddr,
    input  logic [XLEN-1:0]        md_wd,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wd,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] q_count,
    input  logic [4:0]             fwd_addr,
    output logic                   fwd_hit,
    output logic [XLEN-1:0]        fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        reg_onehot = 32'd1 << r;
    endfunction

    // Queue storage and control state
    logic [DEPTH-1:0] valid_r;
    logic [4:0]       addr_r [DEPTH];
    logic [XLEN-1:0]  data_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             rf_we_r;
    logic [4:0]       rf_waddr_r;
    logic [XLEN-1:0]  rf_wd_r;
    logic [31:0]      pending_r;

    logic             pipe_win_s;
    logic             pop_s;
    logic             enq_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [PW-1:0]    head_nxt_s;
    logic [PW-1:0]    tail_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             rf_we_nxt_s;
    logic [4:0]       rf_waddr_nxt_s;
    logic [XLEN-1:0]  rf_wd_nxt_s;
    logic [31:0]      pending_nxt_s;

    assign md_ready   = (count_r != FULL_C);
    // x0 results are handshaken but never occupy a slot.
    assign enq_s      = md_valid & md_ready & (md_waddr != 5'd0);
    assign pipe_win_s = pipe_we & (pipe_waddr != 5'd0);
    // The head is popped whenever the pipeline leaves the port free, valid or cancelled.
    assign pop_s      = ~pipe_win_s & (count_r != {CW{1'b0}});

    // Next-state: port arbitration, WAW cancel, pop, push and pending recompute.
    always_comb begin
        valid_nxt_s    = valid_r;
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        rf_we_nxt_s    = 1'b0;
        rf_waddr_nxt_s = rf_waddr_r;
        rf_wd_nxt_s    = rf_wd_r;
        pending_nxt_s  = 32'd0;

        if (pipe_win_s) begin
            rf_we_nxt_s    = 1'b1;
            rf_waddr_nxt_s = pipe_waddr;
            rf_wd_nxt_s    = pipe_wd;
            // Older queued results to the same register are now stale.
            for (int i = 0; i < DEPTH; i++) begin
                valid_nxt_s[i] = valid_r[i] & (addr_r[i] != pipe_waddr);
            end
        end else if (pop_s) begin
            valid_nxt_s[head_r] = 1'b0;
            head_nxt_s          = head_r + PW'(1);
            if (valid_r[head_r]) begin
                rf_we_nxt_s    = 1'b1;
                rf_waddr_nxt_s = addr_r[head_r];
                rf_wd_nxt_s    = data_r[head_r];
            end else begin
                rf_we_nxt_s    = 1'b0;
            end
        end else begin
            rf_we_nxt_s = 1'b0;
        end

        // Set after the cancel loop: a same-cycle md result is younger than the pipe write.
        if (enq_s) begin
            valid_nxt_s[tail_r] = 1'b1;
            tail_nxt_s          = tail_r + PW'(1);
        end else begin
            tail_nxt_s          = tail_r;
        end

        case ({enq_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt_s = pending_nxt_s | (valid_nxt_s[i] ?
                reg_onehot((enq_s && (tail_r == PW'(i))) ? md_waddr : addr_r[i]) : 32'd0);
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= {DEPTH{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wd_r    <= {XLEN{1'b0}};
            pending_r  <= 32'd0;
        end else begin
            valid_r    <= valid_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            rf_we_r    <= rf_we_nxt_s;
            rf_waddr_r <= rf_waddr_nxt_s;
            rf_wd_r    <= rf_wd_nxt_s;
            pending_r  <= pending_nxt_s;
        end
    end

    // Payload storage; a slot's contents only matter while its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && enq_s) begin
            addr_r[tail_r] <= md_waddr;
            data_r[tail_r] <= md_wd;
        end
    end

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wd    = rf_wd_r;
    assign pending  = pending_r;
    assign q_count  = count_r;

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx_s;

    // Walk from oldest to youngest so the youngest match is the one kept.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = {XLEN{1'b0}};
        fwd_idx_s = head_r;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx_s = head_r + PW'(k);
            if ((fwd_addr != 5'd0) && valid_r[fwd_idx_s] && (addr_r[fwd_idx_s] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_r[fwd_idx_s];
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end
`else
    logic unused_fwd_addr_s;

    assign unused_fwd_addr_s = ^fwd_addr;
    assign fwd_hit           = 1'b0;
    assign fwd_data          = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Bench for wb_write_port_ctrl: directed vectors; expected register-file
// writes go into a queue and a negedge monitor compares every rf_we pulse.
module tb_wb_write_port_ctrl;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            pipe_we;
    logic [4:0]      pipe_waddr;
    logic [XLEN-1:0] pipe_wd;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_waddr;
    logic [XLEN-1:0] md_wd;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wd;
    logic [31:0]     pending;
    logic [2:0]      q_count;
    logic [4:0]      fwd_addr;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    wb_write_port_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wd(pipe_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wd(md_wd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd),
        .pending(pending), .q_count(q_count),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_w;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Drive one cycle of inputs, let the posedge sample them, return 1 ns later.
    task automatic cyc(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_we = pwe; pipe_waddr = pa; pipe_wd = pd;
        md_valid = mv; md_waddr = ma; md_wd = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Scoreboard monitor: every write on the port must match the next expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=%0h, required no write", rf_waddr, rf_wd);
            end else begin
                exp_w = exp_q.pop_front();
                check("rf_write", {27'd0, rf_waddr, rf_wd}, {27'd0, exp_w.a, exp_w.d});
            end
        end
    end

    initial begin
        rst = 1'b1; fwd_addr = 5'd0;
        idle();
        idle();
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_rf_addr_data", {rf_waddr, rf_wd}, 37'd0);
        check("reset_q_count", q_count, 3'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_md_ready", md_ready, 1'b1);
        rst = 1'b0;
        idle();

        // Reset mid-operation: three queued entries are discarded.
        for (int k = 0; k < 3; k++) begin
            push(5'd1, 32'h101 + k);
            cyc(1'b1, 5'd1, 32'h101 + k, 1'b1, 5'(5 + k), 32'h55 + k);
        end
        check("midop_q_count", q_count, 3'd3);
        check("midop_pending", pending, 32'h0000_00E0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("midrst_q_count", q_count, 3'd0);
        check("midrst_pending", pending, 32'd0);
        check("midrst_rf_we", rf_we, 1'b0);
        check("midrst_md_ready", md_ready, 1'b1);
        idle();
        idle();

        // Pipeline priority: x4 waits while x3 writes stream through.
        push(5'd3, 32'h11);
        cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'hAA);
        for (int k = 1; k < 5; k++) begin
            push(5'd3, 32'h11);
            cyc(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        end
        check("prio_pending", pending, 32'h0000_0010);
        check("prio_q_count", q_count, 3'd1);
        push(5'd4, 32'hAA);
        idle();
        check("prio_drain", {rf_we, rf_waddr, rf_wd}, {1'b1, 5'd4, 32'hAA});
        check("prio_q_empty", q_count, 3'd0);

        // No bypass: an md result appears one cycle after it is accepted.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
        check("nobypass_rf_we", rf_we, 1'b0);
        check("nobypass_pending", pending, 32'h0000_0100);
        push(5'd8, 32'h88);
        idle();
        check("nobypass_write", {rf_we, rf_waddr}, {1'b1, 5'd8});

        // Full FIFO, then a refused fifth result, then in-order drain.
        for (int k = 0; k < 4; k++) begin
            push(5'd2, 32'h200 + k);
            cyc(1'b1, 5'd2, 32'h200 + k, 1'b1, 5'(20 + k), 32'hC00 + k);
        end
        check("full_q_count", q_count, 3'd4);
        check("full_md_ready", md_ready, 1'b0);
        check("full_pending", pending, 32'h00F0_0000);
        push(5'd2, 32'h2FF);
        cyc(1'b1, 5'd2, 32'h2FF, 1'b1, 5'd24, 32'h999);
        check("full_refused_count", q_count, 3'd4);
        check("full_refused_pending", pending, 32'h00F0_0000);
        for (int k = 0; k < 4; k++) begin
            push(5'(20 + k), 32'hC00 + k);
            idle();
            check("drain_write", {rf_we, rf_waddr, 27'd0, q_count}, {1'b1, 5'(20 + k), 27'd0, 3'(3 - k)});
        end
        idle();
        check("drain_done_rf_we", rf_we, 1'b0);

        // Simultaneous enqueue and dequeue leaves the count unchanged.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hE);
        push(5'd14, 32'hE);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF);
        check("enq_deq_count", q_count, 3'd1);
        push(5'd15, 32'hF);
        idle();
        idle();

        // WAW cancel: the younger pipeline write to x9 kills the queued 0x1.
        push(5'd2, 32'h300);
        cyc(1'b1, 5'd2, 32'h300, 1'b1, 5'd9, 32'h1);
        check("waw_pending_set", pending, 32'h0000_0200);
        push(5'd9, 32'h2);
        cyc(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        check("waw_count_kept", q_count, 3'd1);
        check("waw_pending_clr", pending, 32'd0);
        idle();
        check("waw_silent_pop", {rf_we, 5'd0, q_count}, {1'b0, 5'd0, 3'd0});

        // Same-cycle enqueue is younger than the pipe write and survives.
        push(5'd9, 32'h3);
        cyc(1'b1, 5'd9, 32'h3, 1'b1, 5'd9, 32'h4);
        check("same_cycle_pending", pending, 32'h0000_0200);
        push(5'd9, 32'h4);
        idle();
        idle();

        // x0 filtering: pipe x0 loses the port, md x0 is dropped, queue drains.
        push(5'd2, 32'h400);
        cyc(1'b1, 5'd2, 32'h400, 1'b1, 5'd16, 32'h16);
        push(5'd16, 32'h16);
        cyc(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        check("x0_drain", {rf_we, rf_waddr, q_count}, {1'b1, 5'd16, 3'd0});
        check("x0_pending", pending, 32'd0);
        idle();
        check("x0_no_write", rf_we, 1'b0);

        // Forwarding lookup over two queued x12 results.
        push(5'd2, 32'h500);
        cyc(1'b1, 5'd2, 32'h500, 1'b1, 5'd12, 32'h10);
        push(5'd2, 32'h501);
        cyc(1'b1, 5'd2, 32'h501, 1'b1, 5'd12, 32'h20);
        check("fwd_pending", pending, 32'h0000_1000);
        fwd_addr = 5'd12;
        #1;
`ifdef WB_FWD_EN
        check("fwd_youngest", {fwd_hit, fwd_data}, {1'b1, 32'h20});
`else
        check("fwd_off", {fwd_hit, fwd_data}, 33'd0);
`endif
        fwd_addr = 5'd13;
        #1;
        check("fwd_miss", fwd_hit, 1'b0);
        fwd_addr = 5'd12;
        push(5'd12, 32'h10);
        idle();
`ifdef WB_FWD_EN
        check("fwd_after_pop", {fwd_hit, fwd_data}, {1'b1, 32'h20});
`else
        check("fwd_off_pop", {fwd_hit, fwd_data}, 33'd0);
`endif
        push(5'd12, 32'h20);
        idle();
        check("fwd_empty", fwd_hit, 1'b0);
        idle();
        idle();

        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_write_port_ctrl.md
Name: wb_write_port_ctrl

Overview:
- Write-side controller for the ID-stage register file.
- Merges the in-order pipeline writeback stream with out-of-order results from the multi-cycle mul/div unit.
- Queues mul/div results in a small FIFO and drives the single register-file write port (we/waddr/wd), one write per cycle.
- Exposes pending-write status and an optional forwarding lookup.

Parameters:
DEPTH, 4, mul/div result FIFO entries (power of 2, >=2)
XLEN, 32, data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; synchronous, active-high
pipe_we  in  1  pipeline writeback valid
pipe_waddr  in  5  pipeline destination register
pipe_wd  in  XLEN  pipeline writeback data
md_valid  in  1  mul/div result valid
md_ready  out  1  FIFO can accept (not full)
md_waddr  in  5  mul/div destination register
md_wd  in  XLEN  mul/div result
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wd  out  XLEN  register-file write data
pending  out  32  bit r set while a queued entry targets xr
q_count  out  log2(DEPTH)+1  FIFO occupancy
fwd_addr  in  5  forwarding lookup address
fwd_hit  out  1  youngest valid queued entry matches fwd_addr
fwd_data  out  XLEN  data of that entry

Behaviour:
- Reset (rst=1 at posedge): rf_we=0, rf_waddr=0, rf_wd=0, FIFO empty, all valid bits 0, q_count=0, pending=0. Reset overrides every other input in that cycle; in-flight queue contents are discarded.
- md_ready = (q_count != DEPTH); combinational from state only.
- Enqueue: md_valid & md_ready at posedge. Writes md_waddr/md_wd at the tail and sets its valid bit. An md_waddr==0 result is accepted and discarded (no entry, count unchanged).
- Port arbitration, evaluated each cycle:
  1. pipe_we=1 and pipe_waddr!=0: pipeline wins. rf_*<=pipe_*, rf_we<=1.
  2. Otherwise, if the FIFO head is valid: dequeue it. rf_*<=head, rf_we<=1.
  3. Otherwise, if the FIFO head slot is invalid (cancelled): pop it silently, rf_we<=0.
  4. Otherwise: rf_we<=0; rf_waddr/rf_wd hold their previous values.
- Latency: outputs are registered, so the write appears on rf_* exactly one cycle after selection. An md result reaches rf_* no earlier than 1 cycle after acceptance; it never bypasses the FIFO in its accept cycle.
- WAW cancel: an accepted pipeline write (pipe_we, waddr!=0) clears the valid bit of every queued entry with the same waddr, since the pipeline write is younger. Count is unchanged; cancelled slots drain via rule 3.
- Same cycle as enqueue: an md entry enqueued in the same cycle as a matching pipeline write is not cancelled (md is younger).
- Simultaneous enqueue and dequeue when full: md_ready=0, so no enqueue. When not full, both occur and q_count is unchanged.
- Pointers wrap modulo DEPTH. q_count is in the range 0..DEPTH.
- pending[r] is the OR over valid entries of (waddr==r). pending[0] is always 0. pending is registered state, recomputed from the valid/addr arrays.
- Invariant: the output order of same-address writes matches age order.

Optional Feature:
WB_FWD_EN
- Defined: fwd_hit/fwd_data are a combinational search for the youngest valid entry with waddr==fwd_addr (fwd_addr!=0). The entry currently on rf_* is not included.
- Undefined: fwd_hit=0 and fwd_data=0 constantly; no search logic.

Test Plan:
- Reset mid-operation: queue 3 md entries (x5,x6,x7), assert rst one cycle -> next cycle q_count=0, pending=0, rf_we=0, md_ready=1.
- Pipeline priority: pipe_we with x3=0x11 every cycle, md x4=0xAA accepted cycle 0 -> rf shows only x3 writes. Drop pipe_we at cycle 5 -> rf_we=1, rf_waddr=4, rf_wd=0xAA in cycle 6.
- Full FIFO: 4 md results with continuous pipe_we -> q_count=4, md_ready=0, 5th md_valid not taken. Idle pipeline -> 4 writes in FIFO order on consecutive cycles.
- WAW cancel: queue x9=0x1, next cycle pipe write x9=0x2 -> rf writes x9=0x2 only. Cancelled slot pops with rf_we=0, pending[9] clears, and x9 is never overwritten by 0x1.
- x0 filtering: pipe_waddr=0 with pipe_we=1 and md x0 result -> rf_we never asserted for addr 0. A queued md entry drains in that cycle.
- WB_FWD_EN: queue x12=0x10 then x12=0x20, fwd_addr=12 -> fwd_hit=1, fwd_data=0x20. fwd_addr=13 -> fwd_hit=0.
